muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Sequencer that owns the architectural HI/LO register pair and runs the multicycle multiply and divide units for the CPU control unit. It accepts one operation per request, latches the operands, and holds the selected unit's go level for a fixed cycle count. It then commits the unit's results to HI/LO and pulses Done. It also handles MTHI/MTLO writes and raises a divide-by-zero exception pulse, in which case HI/LO are left unchanged.

## Interface
- MULT_CYCLES, 33: cycles Mult_Go is held high before results are sampled
- DIV_CYCLES, 34: cycles Div_Go is held high before results are sampled
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  request strobe; sampled only in IDLE
- Op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- A, B  in  32 each  operands (MTHI/MTLO use A)
- Op_A, Op_B  out  32 each  latched operands driven to both units
- Mult_Go, Div_Go  out  1 each  unit control levels
- Mult_HI, Mult_LO, Div_HI, Div_LO  in  32 each  unit results
- Div_Zero_In  in  1  divide unit zero flag
- HI, LO  out  32 each  architectural registers
- Busy  out  1  operation in flight; Start ignored
- Done  out  1  one-cycle completion pulse
- Div_Zero_Exc  out  1  one-cycle exception pulse

## Operation
- States: IDLE, RUN_MULT, RUN_DIV, RELEASE. Counter: 6 bits.
- Reset (any state): state IDLE; all outputs 0, including HI, LO, Op_A, Op_B, Go lines, Busy, Done, Div_Zero_Exc, and the counter.
- IDLE, Start=1, Op=MULT: Op_A←A, Op_B←B, counter←0, next RUN_MULT.
- IDLE, Start=1, Op=DIV, B≠0: same latching, next RUN_DIV.
- IDLE, Start=1, Op=DIV, B=0: no launch. Next RELEASE with Div_Zero_Exc=1. HI/LO unchanged. Done=0.
- IDLE, Start=1, Op=MTHI/MTLO: HI (resp. LO) ←A at this edge. Done=1 the next cycle. State stays IDLE; Busy stays 0.
- RUN_x: the matching Go=1 and the other Go=0. Counter increments each cycle.
- Completion: when counter == x_CYCLES−1 in RUN_x, HI/LO←x_HI/x_LO at that edge. Next RELEASE with Done=1.
- RUN_DIV with Div_Zero_In=1 on any cycle: abort. HI/LO unchanged. Next RELEASE with Div_Zero_Exc=1.
- RELEASE: both Go=0, so the unit sees its falling edge. Busy=1. Next IDLE unconditionally.
- Start while Busy=1 or in RELEASE: ignored, no side effect.
- Done and Div_Zero_Exc are never both 1.
- Op_A/Op_B hold their value until the next accepted MULT/DIV.

## Timing
- Start sampled at edge ending cycle t.
- MULT/DIV: Go high in cycles t+1 … t+N (N = x_CYCLES). HI/LO valid and Done=1 in t+N+1. Busy=1 in t+1 … t+N+1. Earliest next accepted Start is in cycle t+N+2.
- DIV with B=0: Div_Zero_Exc=1 and Busy=1 in t+1; IDLE in t+2.
- Unit-reported zero seen in cycle k: Div_Zero_Exc=1 and Go=0 in k+1; IDLE in k+2.
- MTHI/MTLO: register updated and Done=1 in t+1.
- Outputs are registered; there is no combinational path from Start to any output.

## Structure
- Shared package muldiv_pkg: Op encodings, state encoding (2 bits), MULT_CYCLES/DIV_CYCLES defaults, counter width.
- Sub-module hilo_regs: HI/LO pair with synchronous reset and independent write enables for HI and LO. The sequencer drives the write enables and data.
- The FSM and counter stay in muldiv_sequencer.

## Test plan
- MULT, A=6, B=2, unit model returns HI=0, LO=12 → Mult_Go high exactly 33 cycles; Done at t+34; HI=0, LO=12; Busy falls at t+35.
- DIV, A=8, B=5, model returns HI=3, LO=1 → Div_Go high 34 cycles; Done at t+35; HI=3, LO=1.
- DIV, B=0 → Div_Go never rises; Div_Zero_Exc=1 at t+1; HI/LO keep their prior values (e.g. 3/1).
- MULT running, Start pulses with Op=MTHI A=0xDEADBEEF at cycle t+10 → ignored; final HI/LO come from the multiply only.
- MTLO A=0x12345678 → LO=0x12345678 and Done=1 at t+1, Busy=0 throughout.
- Reset asserted at t+15 of a DIV → next cycle Div_Go=0, HI=LO=0, state IDLE; a new MULT is accepted the cycle after Reset deasserts.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation and
// state encodings, default unit cycle counts and the counter width.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN_MULT = 2'b01,
        ST_RUN_DIV  = 2'b10,
        ST_RELEASE  = 2'b11
    } state_e;

    localparam int MULT_CYCLES_DEF = 33;
    localparam int DIV_CYCLES_DEF  = 34;
    localparam int CNT_W           = 6;

endpackage

// File: rtl/muldiv_sequencer_hilo_regs.sv
// Architectural HI/LO register pair with independent write enables.
// Ports: Clock, Reset (sync, active-high), Hi/Lo write enable + data in,
// Hi_o/Lo_o register outputs.
module hilo_regs (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Hi_We_i,
    input  logic        Lo_We_i,
    input  logic [31:0] Hi_D_i,
    input  logic [31:0] Lo_D_i,
    output logic [31:0] Hi_o,
    output logic [31:0] Lo_o
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (Hi_We_i) hi_q <= Hi_D_i;
            if (Lo_We_i) lo_q <= Lo_D_i;
        end
    end

    assign Hi_o = hi_q;
    assign Lo_o = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the multicycle multiply/divide units; owns HI/LO.
// Ports: Start/Op/A/B request, Op_A/Op_B + Go levels to the units,
// unit results and zero flag in, HI/LO, Busy, Done, Div_Zero_Exc out.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Op_A,
    output logic [31:0] Op_B,
    output logic        Mult_Go,
    output logic        Div_Go,
    input  logic [31:0] Mult_HI,
    input  logic [31:0] Mult_LO,
    input  logic [31:0] Div_HI,
    input  logic [31:0] Div_LO,
    input  logic        Div_Zero_In,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic        Div_Zero_Exc
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        opa_q;
    logic [31:0]        opb_q;
    logic               mult_go_q;
    logic               div_go_q;
    logic               busy_q;
    logic               done_q;
    logic               exc_q;

    op_e                op;
    logic               start_idle;
    logic               mult_last;
    logic               div_last;
    logic               hi_we;
    logic               lo_we;
    logic [31:0]        hi_d;
    logic [31:0]        lo_d;

    assign op         = op_e'(Op);
    assign start_idle = (state_q == ST_IDLE) && Start;
    assign mult_last  = (state_q == ST_RUN_MULT) && (cnt_q == MULT_LAST);
    // A zero report on the final cycle still aborts the commit.
    assign div_last   = (state_q == ST_RUN_DIV) && (cnt_q == DIV_LAST)
                        && !Div_Zero_In;

    always_comb begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_d  = Mult_HI;
        lo_d  = Mult_LO;
        unique case (1'b1)
            mult_last: begin
                hi_we = 1'b1;
                lo_we = 1'b1;
            end
            div_last: begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                hi_d  = Div_HI;
                lo_d  = Div_LO;
            end
            start_idle && (op == OP_MTHI): begin
                hi_we = 1'b1;
                hi_d  = A;
            end
            start_idle && (op == OP_MTLO): begin
                lo_we = 1'b1;
                lo_d  = A;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            mult_go_q <= 1'b0;
            div_go_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            exc_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        unique case (op)
                            OP_MULT: begin
                                opa_q     <= A;
                                opb_q     <= B;
                                cnt_q     <= '0;
                                mult_go_q <= 1'b1;
                                busy_q    <= 1'b1;
                                state_q   <= ST_RUN_MULT;
                            end
                            OP_DIV: begin
                                busy_q <= 1'b1;
                                if (B != '0) begin
                                    opa_q    <= A;
                                    opb_q    <= B;
                                    cnt_q    <= '0;
                                    div_go_q <= 1'b1;
                                    state_q  <= ST_RUN_DIV;
                                end else begin
                                    // Never launch the unit on a known zero divisor.
                                    exc_q   <= 1'b1;
                                    state_q <= ST_RELEASE;
                                end
                            end
                            OP_MTHI, OP_MTLO: begin
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RUN_MULT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == MULT_LAST) begin
                        mult_go_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_RELEASE;
                    end
                end
                ST_RUN_DIV: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (Div_Zero_In) begin
                        div_go_q <= 1'b0;
                        exc_q    <= 1'b1;
                        state_q  <= ST_RELEASE;
                    end else if (cnt_q == DIV_LAST) begin
                        div_go_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Go is low here so the unit sees its falling edge.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    hilo_regs u_hilo (
        .Clock   (Clock),
        .Reset   (Reset),
        .Hi_We_i (hi_we),
        .Lo_We_i (lo_we),
        .Hi_D_i  (hi_d),
        .Lo_D_i  (lo_d),
        .Hi_o    (HI),
        .Lo_o    (LO)
    );

    assign Op_A         = opa_q;
    assign Op_B         = opb_q;
    assign Mult_Go      = mult_go_q;
    assign Div_Go       = div_go_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Div_Zero_Exc = exc_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table with a
// scoreboard queue, plus hand-written multi-cycle corner sequences.
module tb_muldiv_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Op_A;
    logic [31:0] Op_B;
    logic        Mult_Go;
    logic        Div_Go;
    logic [31:0] Mult_HI = '0;
    logic [31:0] Mult_LO = '0;
    logic [31:0] Div_HI = '0;
    logic [31:0] Div_LO = '0;
    logic        Div_Zero_In = 1'b0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        Div_Zero_Exc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        int          go;
        logic        exc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] uhi;
        logic [31:0] ulo;
        exp_t        e;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[6];
    logic [31:0] opa_m = '0;
    logic [31:0] opb_m = '0;

    muldiv_sequencer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .Op           (Op),
        .A            (A),
        .B            (B),
        .Op_A         (Op_A),
        .Op_B         (Op_B),
        .Mult_Go      (Mult_Go),
        .Div_Go       (Div_Go),
        .Mult_HI      (Mult_HI),
        .Mult_LO      (Mult_LO),
        .Div_HI       (Div_HI),
        .Div_LO       (Div_LO),
        .Div_Zero_In  (Div_Zero_In),
        .HI           (HI),
        .LO           (LO),
        .Busy         (Busy),
        .Done         (Done),
        .Div_Zero_Exc (Div_Zero_Exc)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input int go, input logic exc,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input logic busy);
        exp_t e;
        e.lat  = lat;
        e.go   = go;
        e.exc  = exc;
        e.hi   = hi;
        e.lo   = lo;
        e.busy = busy;
        return e;
    endfunction

    // Drive a one-cycle request and record its expected outcome.
    task automatic launch(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e);
        sb.push_back(e);
        if (op == 2'b00 || (op == 2'b01 && b != 0)) begin
            opa_m = a;
            opb_m = b;
        end
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // Wait (bounded) for Done or Div_Zero_Exc and compare against the
    // oldest scoreboard entry. Cycle count starts at 1 on entry.
    task automatic await_done(input string nm);
        exp_t e;
        int   n;
        int   go;
        bit   seen;
        n    = 1;
        go   = 0;
        seen = 1'b0;
        while (n <= 200) begin
            if (Done || Div_Zero_Exc) begin
                seen = 1'b1;
                break;
            end
            if (Mult_Go || Div_Go) go++;
            step();
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no completion within 200 cycles", nm);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: queue empty at completion", nm);
            return;
        end
        e = sb.pop_front();
        if (seen) begin
            chk($sformatf("%s latency", nm), 32'(n), 32'(e.lat));
            chk($sformatf("%s go_cycles", nm), 32'(go), 32'(e.go));
            chk($sformatf("%s exc", nm), 32'(Div_Zero_Exc), 32'(e.exc));
            chk($sformatf("%s done", nm), 32'(Done), 32'(!e.exc));
            chk($sformatf("%s HI", nm), HI, e.hi);
            chk($sformatf("%s LO", nm), LO, e.lo);
            chk($sformatf("%s busy", nm), 32'(Busy), 32'(e.busy));
            chk($sformatf("%s Op_A", nm), Op_A, opa_m);
            chk($sformatf("%s Op_B", nm), Op_B, opb_m);
        end
    endtask

    task automatic post_idle(input string nm);
        step();
        chk($sformatf("%s post busy", nm), 32'(Busy), 32'd0);
        chk($sformatf("%s post pulses", nm),
            32'({Done, Div_Zero_Exc, Mult_Go, Div_Go}), 32'd0);
    endtask

    initial begin
        vt[0] = '{2'b00, 32'd6, 32'd2, 32'd0, 32'd12,
                  mk(34, 33, 1'b0, 32'd0, 32'd12, 1'b1)};
        vt[1] = '{2'b01, 32'd8, 32'd5, 32'd3, 32'd1,
                  mk(35, 34, 1'b0, 32'd3, 32'd1, 1'b1)};
        vt[2] = '{2'b01, 32'd7, 32'd0, 32'hAAAA, 32'hBBBB,
                  mk(1, 0, 1'b1, 32'd3, 32'd1, 1'b1)};
        vt[3] = '{2'b11, 32'h12345678, 32'd0, 32'd0, 32'd0,
                  mk(1, 0, 1'b0, 32'd3, 32'h12345678, 1'b0)};
        vt[4] = '{2'b10, 32'hCAFEF00D, 32'd9, 32'd0, 32'd0,
                  mk(1, 0, 1'b0, 32'hCAFEF00D, 32'h12345678, 1'b0)};
        vt[5] = '{2'b00, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE,
                  mk(34, 33, 1'b0, 32'd1, 32'hFFFFFFFE, 1'b1)};

        // Reset state
        repeat (3) step();
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset Op_A", Op_A, 32'd0);
        chk("reset Op_B", Op_B, 32'd0);
        chk("reset ctl", 32'({Mult_Go, Div_Go, Busy, Done, Div_Zero_Exc}),
            32'd0);
        Reset = 1'b0;
        step();

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            Mult_HI = vt[i].uhi;
            Mult_LO = vt[i].ulo;
            Div_HI  = vt[i].uhi;
            Div_LO  = vt[i].ulo;
            launch(vt[i].op, vt[i].a, vt[i].b, vt[i].e);
            await_done($sformatf("vec%0d", i));
            post_idle($sformatf("vec%0d", i));
        end

        // MTHI pulsed mid-multiply, then MTLO during RELEASE: both ignored
        Mult_HI = 32'd0;
        Mult_LO = 32'd12;
        launch(2'b00, 32'd3, 32'd4, mk(34, 33, 1'b0, 32'd0, 32'd12, 1'b1));
        fork
            begin
                repeat (9) step();
                Op    = 2'b10;
                A     = 32'hDEADBEEF;
                Start = 1'b1;
                step();
                Start = 1'b0;
            end
        join_none
        await_done("mthi_ignored");
        Op    = 2'b11;
        A     = 32'h55;
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("release_start LO", LO, 32'd12);
        chk("release_start HI", HI, 32'd0);
        chk("release_start done", 32'(Done), 32'd0);
        chk("release_start busy", 32'(Busy), 32'd0);
        step();
        chk("release_start late done", 32'(Done), 32'd0);

        // Unit reports zero in cycle t+6: abort, HI/LO unchanged
        Div_HI = 32'hDEAD;
        Div_LO = 32'hBEEF;
        launch(2'b01, 32'd9, 32'd3, mk(7, 6, 1'b1, 32'd0, 32'd12, 1'b1));
        fork
            begin
                repeat (5) step();
                Div_Zero_In = 1'b1;
                step();
                Div_Zero_In = 1'b0;
            end
        join_none
        await_done("unit_zero");
        post_idle("unit_zero");

        // Reset at t+15 of a divide, then a MULT right after
        Div_HI = 32'd3;
        Div_LO = 32'd1;
        launch(2'b01, 32'd8, 32'd5, mk(35, 34, 1'b0, 32'd3, 32'd1, 1'b1));
        repeat (14) step();
        chk("pre_reset div_go", 32'(Div_Go), 32'd1);
        Reset = 1'b1;
        step();
        sb.delete();
        opa_m = '0;
        opb_m = '0;
        chk("mid_reset div_go", 32'(Div_Go), 32'd0);
        chk("mid_reset HI", HI, 32'd0);
        chk("mid_reset LO", LO, 32'd0);
        chk("mid_reset busy", 32'(Busy), 32'd0);
        chk("mid_reset Op_A", Op_A, 32'd0);
        Reset   = 1'b0;
        Mult_HI = 32'd0;
        Mult_LO = 32'd42;
        launch(2'b00, 32'd7, 32'd6, mk(34, 33, 1'b0, 32'd0, 32'd42, 1'b1));
        chk("after_reset mult_go", 32'(Mult_Go), 32'd1);
        chk("after_reset busy", 32'(Busy), 32'd1);
        await_done("after_reset");
        post_idle("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
